// File: rtl/gridding_pkg.sv
// Shared gridding datapath constants; the read-side selector uses the same values.
package gridding_pkg;

  localparam int COMPLEX               = 2;
  localparam int PRECISION             = 32;
  localparam int BRAM_PARALLELISM_BITS = 4;
  localparam int BRAM_DEPTH_BITS       = 10;

  localparam int DATA_WIDTH       = PRECISION * COMPLEX;
  localparam int BRAM_PARALLELISM = 2 ** BRAM_PARALLELISM_BITS;
  localparam int BRAM_WIDTH       = BRAM_PARALLELISM * DATA_WIDTH;
  localparam int ADDR_BITS        = BRAM_DEPTH_BITS + BRAM_PARALLELISM_BITS;

  function automatic int data_path_width(input int parallelism);
    return parallelism * DATA_WIDTH;
  endfunction

endpackage

// File: rtl/window_packer_if.sv
// Window input handshake plus BRAM write-port bundle for window_packer.
interface window_packer_if
  import gridding_pkg::*;
#(
  parameter int PARALLELISM = 15
) ();

  logic                                    in_valid;
  logic                                    in_ready;
  logic [ADDR_BITS-1:0]                    in_addr;
  logic [data_path_width(PARALLELISM)-1:0] in_data;
  logic [BRAM_PARALLELISM-1:0]             bram_we;
  logic [BRAM_DEPTH_BITS-1:0]              bram_addr;
  logic [BRAM_WIDTH-1:0]                   bram_din;
  logic                                    busy;

  modport master (
    output in_valid, in_addr, in_data,
    input  in_ready, bram_we, bram_addr, bram_din, busy
  );

  modport slave (
    input  in_valid, in_addr, in_data,
    output in_ready, bram_we, bram_addr, bram_din, busy
  );

endinterface

// File: rtl/window_packer_shifter.sv
// Places a window at its line offset across a double-width line, with matching lane mask.
module window_shifter
  import gridding_pkg::*;
#(
  parameter int PARALLELISM = 15
) (
  input  logic [PARALLELISM*DATA_WIDTH-1:0] i_data,
  input  logic [BRAM_PARALLELISM_BITS-1:0]  i_offset,
  output logic [2*BRAM_WIDTH-1:0]           o_data,
  output logic [2*BRAM_PARALLELISM-1:0]     o_mask
);

  localparam int DPW = PARALLELISM * DATA_WIDTH;
  localparam logic [2*BRAM_PARALLELISM-1:0] BASE_MASK =
    {{(2*BRAM_PARALLELISM-PARALLELISM){1'b0}}, {PARALLELISM{1'b1}}};

  logic [31:0] w_shamt;

  assign w_shamt = 32'(i_offset) * 32'(DATA_WIDTH);
  // zero padding guarantees lanes outside the mask carry zero data
  assign o_data  = {{(2*BRAM_WIDTH-DPW){1'b0}}, i_data} << w_shamt;
  assign o_mask  = BASE_MASK << i_offset;

endmodule

// File: rtl/window_packer.sv
// Scatters one sample window per handshake into BRAM lines, splitting line-straddling
// windows into two consecutive writes.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | no write presented, ready for a window
//   ST_WR_LO | presenting first (or only) line write of a window
//   ST_WR_HI | presenting second line write of a straddling window
module window_packer
  import gridding_pkg::*;
#(
  parameter int PARALLELISM = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  window_packer_if.slave  bus
);

  localparam int BP  = BRAM_PARALLELISM;
  localparam int BW  = BRAM_WIDTH;
  localparam int BDB = BRAM_DEPTH_BITS;
  localparam int BPB = BRAM_PARALLELISM_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR_LO = 2'd1;
  localparam logic [1:0] ST_WR_HI = 2'd2;

  generate
    if (PARALLELISM > BP) begin : g_bad_parallelism
      $error("window_packer: PARALLELISM must not exceed BRAM_PARALLELISM");
    end
    if ($bits(bus.in_data) != PARALLELISM * DATA_WIDTH) begin : g_bad_if_width
      $error("window_packer: interface PARALLELISM does not match module PARALLELISM");
    end
  endgenerate

  logic [1:0]          r_state;
  logic                r_straddle;
  logic [BP-1:0]       r_we;
  logic [BDB-1:0]      r_addr;
  logic [BW-1:0]       r_din;
  logic [BP-1:0]       r_hi_we;
  logic [BDB-1:0]      r_hi_line;
  logic [BW-1:0]       r_hi_din;

  logic                w_ready;
  logic                w_accept;
  logic [BDB-1:0]      w_line;
  logic [BPB-1:0]      w_offset;
  logic [2*BW-1:0]     w_shifted;
  logic [2*BP-1:0]     w_mask;

  assign w_line   = bus.in_addr[ADDR_BITS-1 -: BDB];
  assign w_offset = bus.in_addr[BPB-1:0];

  window_shifter #(
    .PARALLELISM (PARALLELISM)
  ) u_shifter (
    .i_data   (bus.in_data),
    .i_offset (w_offset),
    .o_data   (w_shifted),
    .o_mask   (w_mask)
  );

  assign w_ready  = (r_state == ST_IDLE) ||
                    (r_state == ST_WR_LO && !r_straddle) ||
                    (r_state == ST_WR_HI);
  assign w_accept = bus.in_valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_straddle <= 1'b0;
      r_we       <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_hi_we    <= '0;
      r_hi_line  <= '0;
      r_hi_din   <= '0;
    end else if (r_state == ST_WR_LO && r_straddle) begin
      r_state    <= ST_WR_HI;
      r_straddle <= 1'b0;
      r_we       <= r_hi_we;
      r_addr     <= r_hi_line;
      r_din      <= r_hi_din;
    end else if (w_accept) begin
      r_state    <= ST_WR_LO;
      r_straddle <= |w_mask[2*BP-1:BP];
      r_we       <= w_mask[BP-1:0];
      r_addr     <= w_line;
      r_din      <= w_shifted[BW-1:0];
      r_hi_we    <= w_mask[2*BP-1:BP];
      r_hi_line  <= w_line + BDB'(1);
      r_hi_din   <= w_shifted[2*BW-1:BW];
    end else begin
      r_state    <= ST_IDLE;
      r_straddle <= 1'b0;
      r_we       <= '0;
      r_addr     <= '0;
      r_din      <= '0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.bram_we   = r_we;
  assign bus.bram_addr = r_addr;
  assign bus.bram_din  = r_din;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_window_packer.sv
// Scoreboard bench for window_packer: expected line writes queued at transfer, checked on output.
module tb_window_packer;

  localparam int P  = 15;
  localparam int DW = 64;
  localparam int BP = 16;
  localparam int BW = BP * DW;
  localparam int DB = 10;

  typedef struct {
    logic [BP-1:0] we;
    logic [DB-1:0] addr;
    logic [BW-1:0] din;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  window_packer_if #(.PARALLELISM(P)) u_if ();

  window_packer #(.PARALLELISM(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  function automatic exp_t make_exp(input logic [13:0] addr, input int base, input bit hi);
    int   off;
    int   k;
    exp_t e;
    off    = int'(addr[3:0]);
    e.we   = '0;
    e.din  = '0;
    e.addr = hi ? 10'(addr[13:4] + 10'd1) : addr[13:4];
    for (int j = 0; j < BP; j++) begin
      k = hi ? (j + BP - off) : (j - off);
      if (k >= 0 && k < P) begin
        e.we[j]            = 1'b1;
        e.din[j*DW +: DW]  = 64'(base + k);
      end
    end
    return e;
  endfunction

  // output monitor: every nonzero write must match the oldest queued expectation
  initial begin
    exp_t e;
    int   dl;
    forever begin
      @(negedge clk);
      if (u_if.bram_we !== '0) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: we=%h addr=%0d, required no write", u_if.bram_we, u_if.bram_addr);
        end else begin
          e  = q.pop_front();
          dl = -1;
          for (int j = BP - 1; j >= 0; j--)
            if (u_if.bram_din[j*DW +: DW] !== e.din[j*DW +: DW]) dl = j;
          if (u_if.bram_we !== e.we || u_if.bram_addr !== e.addr || dl != -1) begin
            n_fail++;
            $display("FAIL line_write: we=%h addr=%0d (required we=%h addr=%0d) first bad lane=%0d got %h required %h",
                     u_if.bram_we, u_if.bram_addr, e.we, e.addr, dl,
                     (dl >= 0) ? u_if.bram_din[dl*DW +: DW] : 64'h0,
                     (dl >= 0) ? e.din[dl*DW +: DW] : 64'h0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [13:0] addr, input int base, input bit push_hi);
    int waited;
    waited         = 0;
    u_if.in_valid  = 1'b1;
    u_if.in_addr   = addr;
    u_if.in_data   = '0;
    for (int k = 0; k < P; k++) u_if.in_data[k*DW +: DW] = 64'(base + k);
    while (u_if.in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 20 cycles", u_if.in_ready);
      u_if.in_valid = 1'b0;
      return;
    end
    q.push_back(make_exp(addr, base, 1'b0));
    if (push_hi && (int'(addr[3:0]) + P > BP)) q.push_back(make_exp(addr, base, 1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (q.size() != 0 && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (u_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: busy=%b, required 0", u_if.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (u_if.bram_we !== '0) begin n_fail++; $display("FAIL reset_we: got %h, required 0", u_if.bram_we); end
    n_tests++;
    if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", u_if.busy); end
    n_tests++;
    if (u_if.bram_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", u_if.bram_addr); end
    n_tests++;
    if (u_if.bram_din !== '0) begin n_fail++; $display("FAIL reset_din: got nonzero, required 0"); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (u_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", u_if.in_ready); end
  endtask

  task automatic test_aligned();
    send(14'h0020, 'h1000, 1'b1);
    u_if.in_valid = 1'b0;
    n_tests++;
    if (u_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL aligned_ready: got %b, required 1", u_if.in_ready); end
    drain();
  endtask

  task automatic test_straddle();
    send(14'h0025, 'h1000, 1'b1);
    u_if.in_valid = 1'b0;
    n_tests++;
    if (u_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL straddle_ready: got %b, required 0", u_if.in_ready); end
    n_tests++;
    if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL straddle_busy: got %b, required 1", u_if.busy); end
    drain();
  endtask

  task automatic test_wrap();
    send(14'h3FF3, 'h1000, 1'b1);
    u_if.in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 6; w++) begin
      n_tests++;
      if (u_if.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready: window %0d in_ready=%b, required 1", w, u_if.in_ready);
      end
      send({10'(10 + w), 4'h1}, 'h1000 + w * 'h100, 1'b1);
    end
    u_if.in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    send(14'h0059, 'h2000, 1'b0);
    u_if.in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (u_if.bram_we !== '0) begin n_fail++; $display("FAIL midrst_we: got %h, required 0", u_if.bram_we); end
    n_tests++;
    if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", u_if.busy); end
    n_tests++;
    if (u_if.bram_addr !== '0 || u_if.bram_din !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: addr=%0d din nonzero=%b, required 0", u_if.bram_addr, |u_if.bram_din);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (u_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b, required 1", u_if.in_ready); end
    drain();
  endtask

  initial begin
    u_if.in_valid = 1'b0;
    u_if.in_addr  = '0;
    u_if.in_data  = '0;
    test_reset();
    test_aligned();
    test_straddle();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
